// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package multdiv_pkg;
  localparam int DATA_W = 32;
  localparam int ITER_N = 32;
  localparam int CNT_W  = 6;
  localparam int TAG_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MULT,
    ST_DIV,
    ST_DONE
  } state_t;
endpackage

// File: rtl/addsub_33.sv
// 33-bit adder/subtractor shared by the Booth step and the restoring-divide step.
module addsub_33
  import multdiv_pkg::*;
(
  input  logic [DATA_W:0] a,
  input  logic [DATA_W:0] b,
  input  logic            sub,
  output logic [DATA_W:0] sum
);
  assign sum = sub ? (a - b) : (a + b);
endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (radix-2 Booth) and signed divide (restoring), one bit per clock.
module multdiv_unit
  import multdiv_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              ctrl_MULT,
  input  logic              ctrl_DIV,
  input  logic [DATA_W-1:0] operand_A,
  input  logic [DATA_W-1:0] operand_B,
  input  logic [TAG_W-1:0]  dest_reg,
  output logic              busy,
  output logic [DATA_W-1:0] result,
  output logic              exception,
  output logic [TAG_W-1:0]  result_reg,
  output logic              result_ready
);
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [DATA_W:0]    acc_q, acc_nxt, booth_acc;
  logic [DATA_W-1:0]  lo_q, lo_nxt, mcand_q;
  logic               qm1_q, neg_q;
  logic [TAG_W-1:0]   tag_q;
  logic [DATA_W:0]    as_a, as_b, as_sum;
  logic               as_sub;
  logic               start, last_iter, div_zero, done_entry;
  logic [DATA_W-1:0]  res_d;
  logic               exc_d;

  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? (~v + 1'b1) : v;
  endfunction

  assign busy         = (state_q == ST_MULT) || (state_q == ST_DIV);
  assign result_ready = (state_q == ST_DONE);
  assign start        = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && (ctrl_MULT || ctrl_DIV);
  assign last_iter    = (cnt_q >= CNT_W'(ITER_N - 1));
  assign div_zero     = (mcand_q == '0);
  assign done_entry   = busy && (state_d == ST_DONE);

  // Divide trials the shifted remainder against the divisor; multiply adds/subtracts the multiplicand.
  always_comb begin
    as_a   = acc_q;
    as_b   = {mcand_q[DATA_W-1], mcand_q};
    as_sub = lo_q[0] & ~qm1_q;
    if (state_q == ST_DIV) begin
      as_a   = {acc_q[DATA_W-1:0], lo_q[DATA_W-1]};
      as_b   = {1'b0, mcand_q};
      as_sub = 1'b1;
    end
  end

  addsub_33 u_addsub (
    .a   (as_a),
    .b   (as_b),
    .sub (as_sub),
    .sum (as_sum)
  );

  always_comb begin
    booth_acc = (lo_q[0] ^ qm1_q) ? as_sum : acc_q;
    acc_nxt   = {booth_acc[DATA_W], booth_acc[DATA_W:1]};
    lo_nxt    = {booth_acc[0], lo_q[DATA_W-1:1]};
    if (state_q == ST_DIV) begin
      if (as_sum[DATA_W]) begin
        acc_nxt = as_a;
        lo_nxt  = {lo_q[DATA_W-2:0], 1'b0};
      end else begin
        acc_nxt = as_sum;
        lo_nxt  = {lo_q[DATA_W-2:0], 1'b1};
      end
    end
  end

  // Only the most-negative quotient without a sign flip (INT_MIN / -1) overflows.
  always_comb begin
    res_d = lo_nxt;
    exc_d = (acc_nxt[DATA_W-1:0] != {DATA_W{lo_nxt[DATA_W-1]}});
    if (state_q == ST_DIV) begin
      if (div_zero) begin
        res_d = '0;
        exc_d = 1'b1;
      end else begin
        res_d = neg_q ? (~lo_nxt + 1'b1) : lo_nxt;
        exc_d = ~neg_q & lo_nxt[DATA_W-1];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (ctrl_MULT)     state_d = ST_MULT;
        else if (ctrl_DIV) state_d = ST_DIV;
        else               state_d = ST_IDLE;
      end
      ST_MULT: if (last_iter) state_d = ST_DONE;
      ST_DIV:  if (div_zero || last_iter) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      lo_q       <= '0;
      mcand_q    <= '0;
      qm1_q      <= 1'b0;
      neg_q      <= 1'b0;
      tag_q      <= '0;
      result     <= '0;
      exception  <= 1'b0;
      result_reg <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        cnt_q <= '0;
        acc_q <= '0;
        qm1_q <= 1'b0;
        tag_q <= dest_reg;
        if (ctrl_MULT) begin
          lo_q    <= operand_B;
          mcand_q <= operand_A;
          neg_q   <= 1'b0;
        end else begin
          lo_q    <= mag(operand_A);
          mcand_q <= mag(operand_B);
          neg_q   <= operand_A[DATA_W-1] ^ operand_B[DATA_W-1];
        end
      end else if (busy) begin
        acc_q <= acc_nxt;
        lo_q  <= lo_nxt;
        qm1_q <= lo_q[0];
        if (cnt_q != CNT_W'(ITER_N)) cnt_q <= cnt_q + 1'b1;
      end
      if (done_entry) begin
        result     <= res_d;
        exception  <= exc_d;
        result_reg <= tag_q;
      end
    end
  end
endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit: arithmetic results, latency, busy, ignore-while-busy, reset abort, back-to-back.
module tb_multdiv_unit;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] operand_A = '0;
  logic [31:0] operand_B = '0;
  logic [4:0]  dest_reg = '0;
  logic        busy;
  logic [31:0] result;
  logic        exception;
  logic [4:0]  result_reg;
  logic        result_ready;

  int n_cmp = 0;
  int n_mis = 0;
  int lat, bc, lat_a, pulses;

  multdiv_unit dut (
    .clock        (clock),
    .reset        (reset),
    .ctrl_MULT    (ctrl_MULT),
    .ctrl_DIV     (ctrl_DIV),
    .operand_A    (operand_A),
    .operand_B    (operand_B),
    .dest_reg     (dest_reg),
    .busy         (busy),
    .result       (result),
    .exception    (exception),
    .result_reg   (result_reg),
    .result_ready (result_ready)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drives a start for one edge, then scrambles the inputs; returns #1 after the start edge.
  task automatic start_op(input logic m, input logic d, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] t);
    @(negedge clock);
    ctrl_MULT = m; ctrl_DIV = d; operand_A = a; operand_B = b; dest_reg = t;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    operand_A = 32'hDEADBEEF; operand_B = 32'h12345678; dest_reg = 5'h1F;
  endtask

  // Edges until result_ready is seen (bounded); bc counts sampled busy-high cycles.
  task automatic wait_ready(output int l, output int b);
    b = busy ? 1 : 0;
    l = 0;
    do begin
      @(posedge clock); #1;
      l++;
      if (!result_ready && busy) b++;
    end while (!result_ready && l < 40);
  endtask

  task automatic check_done(input string tag, input int l, input int exp_lat,
                            input logic [31:0] exp_res, input logic exp_exc, input logic [4:0] exp_reg);
    check({tag, "_lat"}, 32'(l), 32'(exp_lat));
    check({tag, "_rdy"}, 32'(result_ready), 32'd1);
    check({tag, "_res"}, result, exp_res);
    check({tag, "_exc"}, 32'(exception), 32'(exp_exc));
    check({tag, "_reg"}, 32'(result_reg), 32'(exp_reg));
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdy", 32'(result_ready), 32'd0);
    check("rst_res", result, 32'd0);
    check("rst_exc", 32'(exception), 32'd0);
    check("rst_reg", 32'(result_reg), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // 7 * -3 = -21
    start_op(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD, 5'd5);
    wait_ready(lat, bc);
    check_done("mul7x-3", lat, 32, 32'hFFFFFFEB, 1'b0, 5'd5);
    check("mul7x-3_busycyc", 32'(bc), 32'd32);
    @(posedge clock); #1;
    check("after_done_rdy", 32'(result_ready), 32'd0);
    check("after_done_busy", 32'(busy), 32'd0);
    check("after_done_hold", result, 32'hFFFFFFEB);

    start_op(1'b1, 1'b0, 32'h00010000, 32'h00010000, 5'd1);
    wait_ready(lat, bc);
    check_done("mul_ovf", lat, 32, 32'h00000000, 1'b1, 5'd1);

    start_op(1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2);
    wait_ready(lat, bc);
    check_done("mul_m1m1", lat, 32, 32'h00000001, 1'b0, 5'd2);

    start_op(1'b1, 1'b0, 32'h80000000, 32'h80000000, 5'd9);
    wait_ready(lat, bc);
    check_done("mul_minmin", lat, 32, 32'h00000000, 1'b1, 5'd9);

    start_op(1'b1, 1'b0, 32'h80000000, 32'd1, 5'd10);
    wait_ready(lat, bc);
    check_done("mul_minx1", lat, 32, 32'h80000000, 1'b0, 5'd10);

    // both controls high: multiply wins
    start_op(1'b1, 1'b1, 32'd6, 32'd5, 5'd11);
    wait_ready(lat, bc);
    check_done("both_ctrl", lat, 32, 32'd30, 1'b0, 5'd11);

    start_op(1'b0, 1'b1, 32'hFFFFFFF9, 32'd2, 5'd3);
    wait_ready(lat, bc);
    check_done("div-7by2", lat, 32, 32'hFFFFFFFD, 1'b0, 5'd3);
    check("div-7by2_busycyc", 32'(bc), 32'd32);

    start_op(1'b0, 1'b1, 32'd5, 32'd0, 5'd4);
    wait_ready(lat, bc);
    check_done("div_by0", lat, 1, 32'd0, 1'b1, 5'd4);

    start_op(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 5'd12);
    wait_ready(lat, bc);
    check_done("div_minby-1", lat, 32, 32'h80000000, 1'b1, 5'd12);

    start_op(1'b0, 1'b1, 32'd100, 32'hFFFFFFF9, 5'd13);
    wait_ready(lat, bc);
    check_done("div100by-7", lat, 32, 32'hFFFFFFF2, 1'b0, 5'd13);

    // ctrl_DIV and operand_A disturbed mid-multiply
    start_op(1'b1, 1'b0, 32'd6, 32'd7, 5'd7);
    repeat (9) @(posedge clock);
    @(negedge clock);
    ctrl_DIV = 1'b1; operand_A = 32'd100;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0;
    check("ign_busy", 32'(busy), 32'd1);
    wait_ready(lat_a, bc);
    check_done("ign_mul", lat_a + 10, 32, 32'd42, 1'b0, 5'd7);
    pulses = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (result_ready) pulses++;
    end
    check("ign_no_2nd_pulse", 32'(pulses), 32'd0);

    // reset mid-divide
    start_op(1'b0, 1'b1, 32'd100, 32'd7, 5'd6);
    repeat (9) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rdy", 32'(result_ready), 32'd0);
    check("abort_res", result, 32'd0);
    check("abort_exc", 32'(exception), 32'd0);
    check("abort_reg", 32'(result_reg), 32'd0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    pulses = 0;
    repeat (35) begin
      @(posedge clock); #1;
      if (result_ready) pulses++;
    end
    check("abort_no_pulse", 32'(pulses), 32'd0);
    start_op(1'b1, 1'b0, 32'd3, 32'd4, 5'd2);
    wait_ready(lat, bc);
    check_done("mul3x4", lat, 32, 32'd12, 1'b0, 5'd2);

    // back-to-back: multiply started in the DONE cycle of a divide
    start_op(1'b0, 1'b1, 32'd100, 32'd7, 5'd6);
    wait_ready(lat, bc);
    check_done("b2b_div", lat, 32, 32'd14, 1'b0, 5'd6);
    ctrl_MULT = 1'b1; operand_A = 32'hFFFFFFFB; operand_B = 32'd9; dest_reg = 5'd8;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0; operand_A = 32'h0; operand_B = 32'h0; dest_reg = 5'd0;
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_rdy_low", 32'(result_ready), 32'd0);
    check("b2b_hold", result, 32'd14);
    wait_ready(lat, bc);
    check_done("b2b_mul", lat, 32, 32'hFFFFFFD3, 1'b0, 5'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/multdiv_unit.md
MULTDIV_UNIT -- requirements
Module: multdiv_unit

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-low.
REQ-002 SHALL provide these ports (clock and reset first):
  clock  input  1  rising-edge clock for all state
  reset  input  1  asynchronous, active-low; 0 clears all state
  ctrl_MULT  input  1  start a signed multiply; sampled on a rising edge
  ctrl_DIV  input  1  start a signed divide; sampled on a rising edge
  operand_A  input  32  multiplicand or dividend, two's complement
  operand_B  input  32  multiplier or divisor, two's complement
  dest_reg  input  5  destination register tag, latched at start
  busy  output  1  operation in progress; upstream stalls decode_execute while high
  result  output  32  product low word or quotient
  exception  output  1  overflow or divide-by-zero flag for the completed operation
  result_reg  output  5  tag of the completed operation
  result_ready  output  1  one-cycle pulse; result, exception and result_reg are valid in that cycle

Function
REQ-003 SHALL implement states IDLE, MULT, DIV and DONE.
REQ-004 In IDLE or DONE, a rising edge with ctrl_MULT=1 SHALL latch operand_A, operand_B and dest_reg, clear the iteration counter and enter MULT.
REQ-005 In IDLE or DONE, a rising edge with ctrl_DIV=1 and ctrl_MULT=0 SHALL latch the same inputs and enter DIV; if both are 1, MULT wins.
REQ-006 ctrl_MULT and ctrl_DIV SHALL be ignored in MULT and DIV; input changes after the start edge SHALL have no effect.
REQ-007 MULT SHALL perform 32 radix-2 Booth iterations, one per edge, into a 64-bit product, then enter DONE on the 32nd iteration edge; result_ready is high exactly one cycle, 32 edges after the start edge.
REQ-008 MULT result SHALL be product[31:0]; exception SHALL be 1 iff product[63:32] is not all copies of product[31].
REQ-009 DIV SHALL take magnitudes, perform 32 unsigned restoring iterations on a 33-bit partial remainder, then negate the quotient iff the operand signs differ; the quotient truncates toward zero and the remainder is discarded; latency is as in REQ-007.
REQ-010 DIV with operand_B=0 SHALL enter DONE on the edge after the start edge, with result=0 and exception=1 (latency 1).
REQ-011 DIV 0x80000000 / 0xFFFFFFFF SHALL complete in 32 cycles with result=0x80000000 and exception=1.
REQ-012 busy SHALL be 1 exactly in MULT and DIV, and 0 in IDLE and DONE.
REQ-013 DONE SHALL last one cycle, then go to IDLE, unless a start is sampled in DONE (back-to-back per REQ-004/005).
REQ-014 result, exception and result_reg SHALL be registered, load only on DONE entry, and hold their value until the next DONE entry.
REQ-015 The iteration counter SHALL be 6 bits and SHALL never wrap; reaching 32 forces the transition to DONE.

Reset
REQ-016 reset=0 SHALL immediately force IDLE, busy=0, result_ready=0, result=0, exception=0 and result_reg=0, and clear all internal registers.
REQ-017 Reset during MULT or DIV SHALL abort the operation with no result_ready pulse; the first start after reset release behaves as from IDLE.

Structure
REQ-018 A shared package multdiv_pkg SHALL hold the state enumeration, the data width constant (32) and the iteration count constant (32).
REQ-019 One sub-module, addsub_33, SHALL provide the 33-bit add/subtract shared by the Booth and restoring steps; everything else stays in multdiv_unit.

Verification
REQ-020 MULT 7 x 0xFFFFFFFD, dest_reg=5 -> after 32 cycles result_ready=1, result=0xFFFFFFEB, exception=0, result_reg=5; busy high for exactly 32 cycles.
REQ-021 MULT 0x00010000 x 0x00010000 -> result=0x00000000, exception=1; MULT 0xFFFFFFFF x 0xFFFFFFFF -> result=1, exception=0.
REQ-022 DIV 0xFFFFFFF9 / 2 -> result=0xFFFFFFFD, exception=0 after 32 cycles; DIV 5 / 0 -> result_ready one cycle after start, result=0, exception=1.
REQ-023 ctrl_DIV pulsed during cycle 10 of a MULT, and operand_A changed -> ignored; the MULT result is unchanged and no second result_ready pulse occurs.
REQ-024 reset=0 during cycle 10 of a DIV -> outputs 0 at once and no result_ready; a MULT 3 x 4 started after release -> 12 in 32 cycles.
REQ-025 ctrl_MULT asserted in the DONE cycle of a prior DIV -> busy on the next edge, and the second result_ready follows 32 cycles later with the correct product.
